// File: rtl/systolic_feeder_pkg.sv
// Shared constants and state encoding for the systolic array feeder, PE and array top.
package systolic_feeder_pkg;
    localparam int N             = 3;
    localparam int WIDTH_DEFAULT = 4;
    localparam int FEED_LEN      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FEED = 2'b01,
        FIN  = 2'b10
    } state_t;
endpackage

// File: rtl/feeder_skew_mux.sv
// Picks element (c - lane) of one storage row/column, or 0 outside the skew window.
module feeder_skew_mux
    import systolic_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [2:0]         c,
    input  logic [1:0]         lane,
    input  logic [N*WIDTH-1:0] vec,
    output logic [WIDTH-1:0]   elem
);
    logic [2:0] idx;

    always_comb begin
        idx  = c - {1'b0, lane};
        elem = '0;
        if ((c >= {1'b0, lane}) && (idx < 3'(N)))
            elem = vec[idx*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/systolic_feeder.sv
// Stores operand matrices A and B and streams them skewed into a 3x3 systolic array.
module systolic_feeder #(
    parameter int WIDTH = systolic_feeder_pkg::WIDTH_DEFAULT,
    parameter int N     = systolic_feeder_pkg::N
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD_VALID,
    output logic               LOAD_READY,
    input  logic               LOAD_SEL,
    input  logic [1:0]         LOAD_ROW,
    input  logic [N*WIDTH-1:0] LOAD_DATA,
    input  logic               START,
    output logic [WIDTH-1:0]   A_ROW0,
    output logic [WIDTH-1:0]   A_ROW1,
    output logic [WIDTH-1:0]   A_ROW2,
    output logic [WIDTH-1:0]   B_COL0,
    output logic [WIDTH-1:0]   B_COL1,
    output logic [WIDTH-1:0]   B_COL2,
    output logic               ENABLE,
    output logic               BUSY,
    output logic               DONE
);
    import systolic_feeder_pkg::*;

    state_t             state, state_nxt;
    logic [2:0]         c, c_nxt;
    logic [N*WIDTH-1:0] a_mem [N];
    logic [N*WIDTH-1:0] b_mem [N];
    logic [N*WIDTH-1:0] a_nxt [N];
    logic [N*WIDTH-1:0] b_nxt [N];
    logic [N*WIDTH-1:0] b_col [N];
    logic [WIDTH-1:0]   a_sel [N];
    logic [WIDTH-1:0]   b_sel [N];
    logic [WIDTH-1:0]   a_out [N];
    logic [WIDTH-1:0]   b_out [N];
    logic               load_acc;
    logic               en_nxt, busy_nxt, done_nxt, ready_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            c     <= '0;
        end else begin
            state <= state_nxt;
            c     <= c_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = '0;
        case (state)
            IDLE: if (START) state_nxt = FEED;
            FEED: begin
                if (c == 3'(FEED_LEN - 1)) state_nxt = FIN;
                else                       c_nxt     = c + 3'd1;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en_nxt    = (state_nxt == FEED);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == FIN);
        ready_nxt = (state_nxt == IDLE);
    end

    // Muxes see storage with this cycle's load applied, so a load coinciding with START feeds new data.
    assign load_acc = LOAD_VALID && LOAD_READY && (LOAD_ROW != 2'd3);

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            a_nxt[i] = a_mem[i];
            b_nxt[i] = b_mem[i];
            if (load_acc && !LOAD_SEL && (LOAD_ROW == 2'(i))) a_nxt[i] = LOAD_DATA;
            if (load_acc &&  LOAD_SEL && (LOAD_ROW == 2'(i))) b_nxt[i] = LOAD_DATA;
        end
        for (int unsigned j = 0; j < N; j++)
            for (int unsigned k = 0; k < N; k++)
                b_col[j][k*WIDTH +: WIDTH] = b_nxt[k][j*WIDTH +: WIDTH];
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        feeder_skew_mux #(.WIDTH(WIDTH)) u_a_mux (
            .c(c_nxt), .lane(2'(g)), .vec(a_nxt[g]), .elem(a_sel[g])
        );
        feeder_skew_mux #(.WIDTH(WIDTH)) u_b_mux (
            .c(c_nxt), .lane(2'(g)), .vec(b_col[g]), .elem(b_sel[g])
        );
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
                a_out[i] <= '0;
                b_out[i] <= '0;
            end
            ENABLE     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            LOAD_READY <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                a_mem[i] <= a_nxt[i];
                b_mem[i] <= b_nxt[i];
                a_out[i] <= en_nxt ? a_sel[i] : '0;
                b_out[i] <= en_nxt ? b_sel[i] : '0;
            end
            ENABLE     <= en_nxt;
            BUSY       <= busy_nxt;
            DONE       <= done_nxt;
            LOAD_READY <= ready_nxt;
        end
    end

    assign A_ROW0 = a_out[0];
    assign A_ROW1 = a_out[1];
    assign A_ROW2 = a_out[2];
    assign B_COL0 = b_out[0];
    assign B_COL1 = b_out[1];
    assign B_COL2 = b_out[2];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: loads, skewed feed sequences, ignored requests, reset abort.
module tb_systolic_feeder;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         LOAD_VALID, LOAD_READY, LOAD_SEL, START;
    logic [1:0]   LOAD_ROW;
    logic [3*W-1:0] LOAD_DATA;
    logic [W-1:0] A_ROW0, A_ROW1, A_ROW2, B_COL0, B_COL1, B_COL2;
    logic         ENABLE, BUSY, DONE;

    int npass = 0;
    int ntotal = 0;
    int ma [3][3];
    int mb [3][3];

    systolic_feeder #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .LOAD_SEL(LOAD_SEL), .LOAD_ROW(LOAD_ROW), .LOAD_DATA(LOAD_DATA), .START(START),
        .A_ROW0(A_ROW0), .A_ROW1(A_ROW1), .A_ROW2(A_ROW2),
        .B_COL0(B_COL0), .B_COL1(B_COL1), .B_COL2(B_COL2),
        .ENABLE(ENABLE), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_a(input int i, input int c);
        if (c - i >= 0 && c - i <= 2) return 32'(ma[i][c-i]);
        return 0;
    endfunction

    function automatic logic [31:0] exp_b(input int j, input int c);
        if (c - j >= 0 && c - j <= 2) return 32'(mb[c-j][j]);
        return 0;
    endfunction

    task automatic chk_zero_ops(input string tag);
        chk({tag, "_a0"}, 32'(A_ROW0), 0);
        chk({tag, "_a1"}, 32'(A_ROW1), 0);
        chk({tag, "_a2"}, 32'(A_ROW2), 0);
        chk({tag, "_b0"}, 32'(B_COL0), 0);
        chk({tag, "_b1"}, 32'(B_COL1), 0);
        chk({tag, "_b2"}, 32'(B_COL2), 0);
    endtask

    task automatic load(input bit sel, input int row, input int e0, input int e1, input int e2);
        LOAD_VALID = 1'b1;
        LOAD_SEL   = sel;
        LOAD_ROW   = row[1:0];
        LOAD_DATA  = {W'(e2), W'(e1), W'(e0)};
        if (row < 3) begin
            if (sel) begin mb[row][0] = e0; mb[row][1] = e1; mb[row][2] = e2; end
            else     begin ma[row][0] = e0; ma[row][1] = e1; ma[row][2] = e2; end
        end
        tick();
        LOAD_VALID = 1'b0;
    endtask

    // Starts a feed from IDLE (any load already driven by the caller coincides with START)
    // and checks every FEED cycle, FIN and the return to IDLE against the matrix model.
    task automatic feed_check(input string tag, input bit inject);
        START = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("%s_c%0d_a0", tag, c), 32'(A_ROW0), exp_a(0, c));
            chk($sformatf("%s_c%0d_a1", tag, c), 32'(A_ROW1), exp_a(1, c));
            chk($sformatf("%s_c%0d_a2", tag, c), 32'(A_ROW2), exp_a(2, c));
            chk($sformatf("%s_c%0d_b0", tag, c), 32'(B_COL0), exp_b(0, c));
            chk($sformatf("%s_c%0d_b1", tag, c), 32'(B_COL1), exp_b(1, c));
            chk($sformatf("%s_c%0d_b2", tag, c), 32'(B_COL2), exp_b(2, c));
            chk($sformatf("%s_c%0d_en", tag, c), 32'(ENABLE), 1);
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(BUSY), 1);
            chk($sformatf("%s_c%0d_done", tag, c), 32'(DONE), 0);
            chk($sformatf("%s_c%0d_rdy", tag, c), 32'(LOAD_READY), 0);
            START      = 1'b0;
            LOAD_VALID = 1'b0;
            if (inject && c == 2) begin
                START      = 1'b1;
                LOAD_VALID = 1'b1;
                LOAD_SEL   = 1'b0;
                LOAD_ROW   = 2'd0;
                LOAD_DATA  = '1;
            end
            tick();
        end
        chk({tag, "_fin_done"}, 32'(DONE), 1);
        chk({tag, "_fin_busy"}, 32'(BUSY), 1);
        chk({tag, "_fin_en"}, 32'(ENABLE), 0);
        chk_zero_ops({tag, "_fin"});
        tick();
        chk({tag, "_idle_done"}, 32'(DONE), 0);
        chk({tag, "_idle_busy"}, 32'(BUSY), 0);
        chk({tag, "_idle_rdy"}, 32'(LOAD_READY), 1);
        chk_zero_ops({tag, "_idle"});
    endtask

    initial begin
        RST = 1'b0; LOAD_VALID = 1'b0; LOAD_SEL = 1'b0; LOAD_ROW = '0; LOAD_DATA = '0; START = 1'b0;
        foreach (ma[i, j]) begin ma[i][j] = 0; mb[i][j] = 0; end

        #2;
        chk("rst_rdy", 32'(LOAD_READY), 0);
        chk("rst_en", 32'(ENABLE), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk_zero_ops("rst");
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(LOAD_READY), 1);

        // A = 1..9, B = identity
        load(0, 0, 1, 2, 3);
        load(0, 1, 4, 5, 6);
        load(0, 2, 7, 8, 9);
        load(1, 0, 1, 0, 0);
        load(1, 1, 0, 1, 0);
        load(1, 2, 0, 0, 1);
        feed_check("ident", 0);

        // B = all ones, then START repeated without reloading
        load(1, 0, 1, 1, 1);
        load(1, 1, 1, 1, 1);
        load(1, 2, 1, 1, 1);
        feed_check("ones", 0);
        feed_check("refeed", 0);

        // START and a load request during FEED are ignored; re-feed proves storage intact
        feed_check("inject", 1);
        feed_check("after_inject", 0);

        // Row index 3 is dropped for both matrices
        load(0, 3, 15, 15, 15);
        load(1, 3, 15, 15, 15);
        feed_check("row3", 0);

        // Reset at FEED c=3 aborts immediately with no DONE
        START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        chk("pre_abort_a2", 32'(A_ROW2), exp_a(2, 3));
        chk("pre_abort_b1", 32'(B_COL1), exp_b(1, 3));
        RST = 1'b0;
        #1;
        chk("abort_en", 32'(ENABLE), 0);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_done", 32'(DONE), 0);
        chk("abort_rdy", 32'(LOAD_READY), 0);
        chk_zero_ops("abort");
        foreach (ma[i, j]) begin ma[i][j] = 0; mb[i][j] = 0; end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort_hold%0d_done", k), 32'(DONE), 0);
        end
        RST = 1'b1;
        tick();
        chk("rel_rdy", 32'(LOAD_READY), 1);
        chk("rel_done", 32'(DONE), 0);
        feed_check("cleared", 0);

        load(0, 0, 1, 2, 3);
        load(0, 1, 4, 5, 6);
        load(0, 2, 7, 8, 9);
        load(1, 0, 2, 3, 4);
        load(1, 1, 5, 6, 7);
        load(1, 2, 8, 9, 10);
        feed_check("reload", 0);

        // Load A row 0 = [5,5,5] in the same cycle as START
        LOAD_VALID = 1'b1;
        LOAD_SEL   = 1'b0;
        LOAD_ROW   = 2'd0;
        LOAD_DATA  = {W'(5), W'(5), W'(5)};
        ma[0][0] = 5; ma[0][1] = 5; ma[0][2] = 5;
        feed_check("coincide", 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
